// File: rtl/cep_define.sv
// Shared PMP definitions: oper encodings, pmpcfg byte layout, arbiter FSM states and requester ids.
package cep_define;

   localparam logic [1:0] READ  = 2'b00;
   localparam logic [1:0] WRITE = 2'b01;
   localparam logic [1:0] EXEC  = 2'b10;
   localparam logic [1:0] OPER_ILLEGAL = 2'b11;

   typedef struct packed {
      logic       l;
      logic [1:0] rsvd;
      logic [1:0] a;
      logic       x;
      logic       w;
      logic       r;
   } pmpcfg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      RESP     = 3'd2,
      CSR_ACC  = 3'd3,
      CSR_RESP = 3'd4
   } arb_state_e;

   typedef enum logic [1:0] {
      SRC_IF  = 2'd0,
      SRC_LS  = 2'd1,
      SRC_CSR = 2'd2
   } req_src_e;

   localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
   localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
   localparam logic [1:0]  PERM_ALLOW   = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is granted.
module rr_arb2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic r_last;   // 0 = requester 0 won last, 1 = requester 1 won last

   always_comb begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
      if (i_en && i_req0 && i_req1) begin
         o_gnt0 = r_last;
         o_gnt1 = ~r_last;
      end else if (i_en) begin
         o_gnt0 = i_req0;
         o_gnt1 = i_req1;
      end else begin
         o_gnt0 = 1'b0;
         o_gnt1 = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)       r_last <= 1'b1;
      else if (o_gnt0) r_last <= 1'b0;
      else if (o_gnt1) r_last <= 1'b1;
      else             r_last <= r_last;
   end

endmodule

// File: rtl/pmp_arbiter.sv
// Shares one pmp checker between IF, LS and CSR requesters; CSR has priority, IF/LS round-robin.
// Optional saturating fault counter output enabled by macro PMP_ARB_FAULT_CNT_EN.
module pmp_arbiter
   import cep_define::*;
#(
   parameter int CSR_ADDR_W = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [31:0]           if_addr,
   input  logic [1:0]            if_priv,
   output logic                  if_rsp_valid,
   output logic                  if_rsp_fault,
   input  logic                  ls_req_valid,
   output logic                  ls_req_ready,
   input  logic [31:0]           ls_addr,
   input  logic [1:0]            ls_priv,
   input  logic [1:0]            ls_size,
   input  logic [1:0]            ls_oper,
   output logic                  ls_rsp_valid,
   output logic                  ls_rsp_fault,
   input  logic                  csr_req_valid,
   output logic                  csr_req_ready,
   input  logic                  csr_we,
   input  logic [CSR_ADDR_W-1:0] csr_addr,
   input  logic [31:0]           csr_wdata,
   output logic                  csr_rsp_valid,
   output logic [31:0]           csr_rdata,
   output logic [31:0]           pmp_addr,
   output logic [1:0]            pmp_priv_mode,
   output logic [1:0]            pmp_size,
   output logic [1:0]            pmp_oper,
   input  logic [1:0]            pmp_permission,
   output logic                  pmp_wr_en,
   output logic [31:0]           pmp_rw_addr,
   output logic [31:0]           pmp_wdata,
   input  logic [31:0]           pmp_rdata
`ifdef PMP_ARB_FAULT_CNT_EN
   ,
   output logic [15:0]           fault_count
`endif
);

   arb_state_e r_state, w_next;
   req_src_e   r_src;
   logic       r_illegal, r_csr_we;
   logic       r_if_rsp_valid, r_if_rsp_fault, r_ls_rsp_valid, r_ls_rsp_fault;
   logic       r_csr_rsp_valid, r_pmp_wr_en;
   logic [31:0] r_csr_rdata, r_pmp_addr, r_pmp_rw_addr, r_pmp_wdata;
   logic [1:0]  r_pmp_priv, r_pmp_size, r_pmp_oper;
   logic w_idle, w_csr_gnt, w_if_gnt, w_ls_gnt, w_fault;

   assign w_idle    = (r_state == IDLE) && !reset;
   assign w_csr_gnt = w_idle && csr_req_valid;
   assign w_fault   = (pmp_permission != PERM_ALLOW) || r_illegal;

   rr_arb2 u_rr_arb2 (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_en   (w_idle && !csr_req_valid),
      .i_req0 (if_req_valid),
      .i_req1 (ls_req_valid),
      .o_gnt0 (w_if_gnt),
      .o_gnt1 (w_ls_gnt)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_csr_gnt)                  w_next = CSR_ACC;
            else if (w_if_gnt || w_ls_gnt)  w_next = CHECK;
            else                            w_next = IDLE;
         end
         CHECK:    w_next = RESP;
         RESP:     w_next = IDLE;
         CSR_ACC:  w_next = CSR_RESP;
         CSR_RESP: w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Operand latching, pmp drive, response capture; strobes default low each cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_src           <= SRC_IF;
         r_illegal       <= 1'b0;
         r_csr_we        <= 1'b0;
         r_if_rsp_valid  <= 1'b0;
         r_if_rsp_fault  <= 1'b0;
         r_ls_rsp_valid  <= 1'b0;
         r_ls_rsp_fault  <= 1'b0;
         r_csr_rsp_valid <= 1'b0;
         r_pmp_wr_en     <= 1'b0;
         r_csr_rdata     <= 32'h0000_0000;
         r_pmp_addr      <= 32'h0000_0000;
         r_pmp_rw_addr   <= 32'h0000_0000;
         r_pmp_wdata     <= 32'h0000_0000;
         r_pmp_priv      <= 2'b01;
         r_pmp_size      <= 2'b00;
         r_pmp_oper      <= READ;
      end else begin
         r_if_rsp_valid  <= 1'b0;
         r_ls_rsp_valid  <= 1'b0;
         r_csr_rsp_valid <= 1'b0;
         r_pmp_wr_en     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_csr_gnt) begin
                  r_src         <= SRC_CSR;
                  r_csr_we      <= csr_we;
                  r_pmp_rw_addr <= {{(32-CSR_ADDR_W){1'b0}}, csr_addr};
                  r_pmp_wdata   <= csr_wdata;
                  r_pmp_wr_en   <= csr_we;
                  r_pmp_priv    <= 2'b00;
               end else if (w_if_gnt) begin
                  r_src      <= SRC_IF;
                  r_illegal  <= 1'b0;
                  r_pmp_addr <= if_addr;
                  r_pmp_priv <= if_priv;
                  r_pmp_size <= 2'b11;
                  r_pmp_oper <= EXEC;
               end else if (w_ls_gnt) begin
                  r_src      <= SRC_LS;
                  r_illegal  <= (ls_oper == OPER_ILLEGAL);
                  r_pmp_addr <= ls_addr;
                  r_pmp_priv <= ls_priv;
                  r_pmp_size <= ls_size;
                  r_pmp_oper <= ls_oper;
               end else begin
                  r_src <= r_src;
               end
            end
            CHECK: begin
               if (r_src == SRC_IF) begin
                  r_if_rsp_valid <= 1'b1;
                  r_if_rsp_fault <= w_fault;
               end else begin
                  r_ls_rsp_valid <= 1'b1;
                  r_ls_rsp_fault <= w_fault;
               end
            end
            CSR_ACC: begin
               r_csr_rsp_valid <= 1'b1;
               if (!r_csr_we) r_csr_rdata <= pmp_rdata;
               else           r_csr_rdata <= r_csr_rdata;
            end
            CSR_RESP: r_pmp_priv <= 2'b01;
            default:  r_src <= r_src;
         endcase
      end
   end

`ifdef PMP_ARB_FAULT_CNT_EN
   logic [15:0] r_fault_count;
   logic        w_resp_fault;
   assign w_resp_fault = (r_src == SRC_IF) ? r_if_rsp_fault : r_ls_rsp_fault;

   always_ff @(posedge clock) begin
      if (reset)
         r_fault_count <= 16'h0000;
      else if ((r_state == RESP) && w_resp_fault && (r_fault_count != 16'hFFFF))
         r_fault_count <= r_fault_count + 16'h0001;
      else
         r_fault_count <= r_fault_count;
   end
   assign fault_count = r_fault_count;
`endif

   assign if_req_ready  = w_if_gnt;
   assign ls_req_ready  = w_ls_gnt;
   assign csr_req_ready = w_csr_gnt;
   assign if_rsp_valid  = r_if_rsp_valid;
   assign if_rsp_fault  = r_if_rsp_fault;
   assign ls_rsp_valid  = r_ls_rsp_valid;
   assign ls_rsp_fault  = r_ls_rsp_fault;
   assign csr_rsp_valid = r_csr_rsp_valid;
   assign csr_rdata     = r_csr_rdata;
   assign pmp_addr      = r_pmp_addr;
   assign pmp_priv_mode = r_pmp_priv;
   assign pmp_size      = r_pmp_size;
   assign pmp_oper      = r_pmp_oper;
   assign pmp_wr_en     = r_pmp_wr_en;
   assign pmp_rw_addr   = r_pmp_rw_addr;
   assign pmp_wdata     = r_pmp_wdata;

endmodule

// File: tb/tb_pmp_arbiter.sv
// Self-checking bench for pmp_arbiter: directed scenarios plus randomized traffic against a PMP stub and reference model.
module tb_pmp_arbiter;
   import cep_define::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_fault;
   logic [31:0] if_addr;
   logic [1:0]  if_priv;
   logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_fault;
   logic [31:0] ls_addr;
   logic [1:0]  ls_priv, ls_size, ls_oper;
   logic        csr_req_valid, csr_req_ready, csr_we, csr_rsp_valid;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic [31:0] pmp_addr, pmp_rw_addr, pmp_wdata, pmp_rdata;
   logic [1:0]  pmp_priv_mode, pmp_size, pmp_oper, pmp_permission;
   logic        pmp_wr_en;
`ifdef PMP_ARB_FAULT_CNT_EN
   logic [15:0] fault_count;
`endif

   always #5 clock = ~clock;

   pmp_arbiter #(.CSR_ADDR_W(12)) dut (
`ifdef PMP_ARB_FAULT_CNT_EN
      .fault_count    (fault_count),
`endif
      .clock          (clock),
      .reset          (reset),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_addr        (if_addr),
      .if_priv        (if_priv),
      .if_rsp_valid   (if_rsp_valid),
      .if_rsp_fault   (if_rsp_fault),
      .ls_req_valid   (ls_req_valid),
      .ls_req_ready   (ls_req_ready),
      .ls_addr        (ls_addr),
      .ls_priv        (ls_priv),
      .ls_size        (ls_size),
      .ls_oper        (ls_oper),
      .ls_rsp_valid   (ls_rsp_valid),
      .ls_rsp_fault   (ls_rsp_fault),
      .csr_req_valid  (csr_req_valid),
      .csr_req_ready  (csr_req_ready),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rsp_valid  (csr_rsp_valid),
      .csr_rdata      (csr_rdata),
      .pmp_addr       (pmp_addr),
      .pmp_priv_mode  (pmp_priv_mode),
      .pmp_size       (pmp_size),
      .pmp_oper       (pmp_oper),
      .pmp_permission (pmp_permission),
      .pmp_wr_en      (pmp_wr_en),
      .pmp_rw_addr    (pmp_rw_addr),
      .pmp_wdata      (pmp_wdata),
      .pmp_rdata      (pmp_rdata)
   );

   // TOR-only PMP decision over entries 0..3 (cfg byte i of pmpcfg0); no match means M-mode only.
   function automatic logic pmp_allows(input logic [31:0] cfg0, input logic [3:0][31:0] pa,
                                       input logic [31:0] addr, input logic [1:0] size,
                                       input logic [1:0] priv, input logic [1:0] oper);
      logic [33:0] lo, hi, first, last;
      logic [7:0]  c;
      first = {2'b00, addr};
      last  = first + {32'h0, size};
      lo    = 34'h0;
      for (int i = 0; i < 4; i++) begin
         c  = cfg0[8*i +: 8];
         hi = {pa[i], 2'b00};
         if (c[4:3] == 2'b01 && first >= lo && last < hi) begin
            if (oper == 2'b00) return c[0];
            if (oper == 2'b01) return c[1];
            if (oper == 2'b10) return c[2];
            return 1'b0;
         end
         lo = hi;
      end
      return (priv == 2'b11);
   endfunction

   // PMP stub: register file written through the DUT's register port, permission from DUT check pins
   logic [31:0] st_cfg [4]  = '{default: 32'h0};
   logic [31:0] st_pa  [16] = '{default: 32'h0};
   logic [1:0]  deny_code = 2'b00;

   always @(posedge clock) begin
      if (pmp_wr_en && pmp_rw_addr >= 32'h3A0 && pmp_rw_addr <= 32'h3A3) st_cfg[pmp_rw_addr[1:0]] <= pmp_wdata;
      if (pmp_wr_en && pmp_rw_addr >= 32'h3B0 && pmp_rw_addr <= 32'h3BF) st_pa[pmp_rw_addr[3:0]] <= pmp_wdata;
   end

   always_comb begin
      pmp_rdata = 32'h0;
      if (pmp_rw_addr >= 32'h3A0 && pmp_rw_addr <= 32'h3A3) pmp_rdata = st_cfg[pmp_rw_addr[1:0]];
      else if (pmp_rw_addr >= 32'h3B0 && pmp_rw_addr <= 32'h3BF) pmp_rdata = st_pa[pmp_rw_addr[3:0]];
      pmp_permission = pmp_allows(st_cfg[0], {st_pa[3], st_pa[2], st_pa[1], st_pa[0]},
                                  pmp_addr, pmp_size, pmp_priv_mode, pmp_oper) ? 2'b11 : deny_code;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference state: programmed PMP contents, round-robin memory, expected read data and fault count
   logic [31:0] sh_cfg [4]  = '{default: 32'h0};
   logic [31:0] sh_pa  [16] = '{default: 32'h0};
   bit          m_last_ls = 1'b1;
   logic [31:0] exp_rdata = 32'h0;
   int          exp_fc = 0;
   int          n_pass = 0, n_total = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_fault(input bit is_if, input logic [31:0] addr, input logic [1:0] priv,
                                        input logic [1:0] size, input logic [1:0] oper);
      logic [1:0] op, sz;
      op = is_if ? EXEC : oper;
      sz = is_if ? 2'b11 : size;
      if (!is_if && oper == 2'b11) return 1'b1;
      return !pmp_allows(sh_cfg[0], {sh_pa[3], sh_pa[2], sh_pa[1], sh_pa[0]}, addr, sz, priv, op);
   endfunction

   function automatic logic [31:0] sh_read(input logic [11:0] a);
      if (a >= 12'h3A0 && a <= 12'h3A3) return sh_cfg[a[1:0]];
      if (a >= 12'h3B0 && a <= 12'h3BF) return sh_pa[a[3:0]];
      return 32'h0;
   endfunction

   task automatic count_fault(input logic f);
      if (f && exp_fc < 65535) exp_fc++;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0; csr_req_valid = 1'b0;
      @(negedge clock); #1;
      check("rst_if_rsp_valid", if_rsp_valid, 1'b0);
      check("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
      check("rst_csr_rsp_valid", csr_rsp_valid, 1'b0);
      check("rst_faults", {if_rsp_fault, ls_rsp_fault}, 2'b00);
      check("rst_wr_en", pmp_wr_en, 1'b0);
      check("rst_csr_rdata", csr_rdata, 32'h0);
      check("rst_pmp_addr", pmp_addr, 32'h0);
      check("rst_rw_addr", pmp_rw_addr, 32'h0);
      check("rst_wdata", pmp_wdata, 32'h0);
      check("rst_priv", pmp_priv_mode, 2'b01);
      check("rst_oper", pmp_oper, READ);
      check("rst_size", pmp_size, 2'b00);
`ifdef PMP_ARB_FAULT_CNT_EN
      check("rst_fault_count", fault_count, 16'h0);
`endif
      reset = 1'b0;
      m_last_ls = 1'b1;
      exp_rdata = 32'h0;
      exp_fc = 0;
   endtask

   task automatic csr_op(input logic we, input logic [11:0] a, input logic [31:0] d);
      int k;
      csr_we = we; csr_addr = a; csr_wdata = d; csr_req_valid = 1'b1;
      #1;
      k = 0;
      while (!csr_req_ready && k < 10) begin @(negedge clock); #1; k++; end
      check("csr_ready", csr_req_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      csr_req_valid = 1'b0;
      #1;
      check("csr_acc_wr_en", pmp_wr_en, we);
      check("csr_acc_priv", pmp_priv_mode, 2'b00);
      check("csr_acc_rw_addr", pmp_rw_addr, {20'h0, a});
      if (we) check("csr_acc_wdata", pmp_wdata, d);
      if (we) begin
         if (a >= 12'h3A0 && a <= 12'h3A3) sh_cfg[a[1:0]] = d;
         if (a >= 12'h3B0 && a <= 12'h3BF) sh_pa[a[3:0]] = d;
      end else begin
         exp_rdata = sh_read(a);
      end
      @(negedge clock); #1;
      check("csr_rsp_valid", csr_rsp_valid, 1'b1);
      check("csr_resp_wr_en", pmp_wr_en, 1'b0);
      check("csr_resp_priv", pmp_priv_mode, 2'b00);
      check("csr_rdata", csr_rdata, exp_rdata);
   endtask

   task automatic issue(input bit is_if, input logic [31:0] a, input logic [1:0] priv,
                        input logic [1:0] size, input logic [1:0] oper);
      int k;
      logic ef;
      ef = model_fault(is_if, a, priv, size, oper);
      if (is_if) begin
         if_addr = a; if_priv = priv; if_req_valid = 1'b1;
      end else begin
         ls_addr = a; ls_priv = priv; ls_size = size; ls_oper = oper; ls_req_valid = 1'b1;
      end
      #1;
      k = 0;
      while (!(is_if ? if_req_ready : ls_req_ready) && k < 10) begin @(negedge clock); #1; k++; end
      check(is_if ? "if_ready" : "ls_ready", is_if ? if_req_ready : ls_req_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      #1;
      check("chk_rsp_early", {if_rsp_valid, ls_rsp_valid}, 2'b00);
      check("chk_pmp_addr", pmp_addr, a);
      check("chk_pmp_oper", pmp_oper, is_if ? EXEC : oper);
      check("chk_pmp_size", pmp_size, is_if ? 2'b11 : size);
      check("chk_pmp_priv", pmp_priv_mode, priv);
      @(negedge clock); #1;
      check(is_if ? "if_rsp_valid" : "ls_rsp_valid", {if_rsp_valid, ls_rsp_valid}, is_if ? 2'b10 : 2'b01);
      check(is_if ? "if_rsp_fault" : "ls_rsp_fault", is_if ? if_rsp_fault : ls_rsp_fault, ef);
      m_last_ls = !is_if;
      count_fault(ef);
   endtask

   // IF and LS both valid: winner decided by the model's last-grant memory, loser follows one slot later
   task automatic tie(input logic [31:0] ia, input logic [1:0] ip,
                      input logic [31:0] la, input logic [1:0] lp, input logic [1:0] lsz, input logic [1:0] lop);
      int k, t1;
      bit if_first;
      logic fi, fl;
      fi = model_fault(1'b1, ia, ip, 2'b11, EXEC);
      fl = model_fault(1'b0, la, lp, lsz, lop);
      if_addr = ia; if_priv = ip; if_req_valid = 1'b1;
      ls_addr = la; ls_priv = lp; ls_size = lsz; ls_oper = lop; ls_req_valid = 1'b1;
      #1;
      k = 0;
      while (!(if_req_ready || ls_req_ready) && k < 10) begin @(negedge clock); #1; k++; end
      if_first = m_last_ls;
      check("tie_if_ready", if_req_ready, if_first);
      check("tie_ls_ready", ls_req_ready, !if_first);
      @(posedge clock);
      @(negedge clock);
      if (if_first) if_req_valid = 1'b0; else ls_req_valid = 1'b0;
      #1;
      check("tie_busy_ready", {if_req_ready, ls_req_ready}, 2'b00);
      @(negedge clock); #1;
      t1 = cyc;
      check("tie_first_rsp", {if_rsp_valid, ls_rsp_valid}, if_first ? 2'b10 : 2'b01);
      check("tie_first_fault", if_first ? if_rsp_fault : ls_rsp_fault, if_first ? fi : fl);
      @(negedge clock); #1;
      check("tie_second_ready", if_first ? ls_req_ready : if_req_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      @(negedge clock); #1;
      check("tie_second_rsp", {if_rsp_valid, ls_rsp_valid}, if_first ? 2'b01 : 2'b10);
      check("tie_second_fault", if_first ? ls_rsp_fault : if_rsp_fault, if_first ? fl : fi);
      check("tie_spacing", cyc - t1, 3);
      m_last_ls = if_first;
      count_fault(fi);
      count_fault(fl);
   endtask

   initial begin
      int k;
      logic [11:0] ra;
      reset = 1'b1;
      if_req_valid = 1'b0; if_addr = 32'h0; if_priv = 2'b01;
      ls_req_valid = 1'b0; ls_addr = 32'h0; ls_priv = 2'b01; ls_size = 2'b00; ls_oper = READ;
      csr_req_valid = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
      repeat (3) @(negedge clock);
      do_reset();

      // Allowed fetch
      csr_op(1'b1, 12'h3B0, 32'h0000_1000);
      csr_op(1'b1, 12'h3A0, 32'h0000_000F);
      issue(1'b1, 32'h0000_0100, 2'b01, 2'b00, EXEC);

      // Write denied, read allowed
      csr_op(1'b1, 12'h3A0, 32'h0000_0009);
      deny_code = 2'b00;
      issue(1'b0, 32'h0000_0100, 2'b01, 2'b11, WRITE);
      issue(1'b0, 32'h0000_0100, 2'b01, 2'b11, READ);

      // Round-robin right after reset: IF first
      do_reset();
      tie(32'h0000_0200, 2'b01, 32'h0000_0300, 2'b01, 2'b01, WRITE);

      // CSR priority over simultaneous IF/LS, then read back pmpcfg0
      @(negedge clock);
      if_req_valid = 1'b1; ls_req_valid = 1'b1; csr_req_valid = 1'b1;
      csr_we = 1'b0; csr_addr = 12'h3A0;
      #1;
      check("prio_csr_ready", {csr_req_ready, if_req_ready, ls_req_ready}, 3'b100);
      csr_op(1'b0, 12'h3A0, 32'h0);
      tie(32'h0000_0400, 2'b00, 32'h0000_0500, 2'b00, 2'b00, READ);

      // Reset during CHECK drops the request
      ls_addr = 32'h0000_0100; ls_priv = 2'b01; ls_size = 2'b00; ls_oper = READ; ls_req_valid = 1'b1;
      #1;
      k = 0;
      while (!ls_req_ready && k < 10) begin @(negedge clock); #1; k++; end
      check("mid_rst_accept", ls_req_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      ls_req_valid = 1'b0; reset = 1'b1;
      @(negedge clock); #1;
      check("mid_rst_no_rsp", ls_rsp_valid, 1'b0);
      check("mid_rst_priv", pmp_priv_mode, 2'b01);
      reset = 1'b0; m_last_ls = 1'b1; exp_rdata = 32'h0; exp_fc = 0;
      @(negedge clock); #1;
      check("mid_rst_no_rsp2", ls_rsp_valid, 1'b0);
      ls_req_valid = 1'b1; #1;
      check("mid_rst_idle_ready", ls_req_ready, 1'b1);
      ls_req_valid = 1'b0;

      // Illegal oper forced to fault even where permission would allow
      deny_code = 2'b01;
      issue(1'b0, 32'h0000_0100, 2'b11, 2'b00, 2'b11);

      // Randomized traffic
      for (int it = 0; it < 70; it++) begin
         deny_code = 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0: csr_op(1'b1, 12'h3A0, $urandom & 32'h1F1F_1F1F);
            1: begin
               ra = 12'h3B0 + 12'($urandom_range(0, 3));
               csr_op(1'b1, ra, 32'($urandom_range(0, 32'h1800)));
            end
            2: begin
               ra = ($urandom_range(0, 1) == 0) ? 12'h3A0 + 12'($urandom_range(0, 3))
                                                  : 12'h3B0 + 12'($urandom_range(0, 15));
               csr_op(1'b0, ra, 32'h0);
            end
            3: tie(32'($urandom_range(0, 32'h6000)), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 32'h6000)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            4, 5, 6: issue(1'b1, 32'($urandom_range(0, 32'h6000)), 2'($urandom_range(0, 3)), 2'b00, EXEC);
            default: issue(1'b0, 32'($urandom_range(0, 32'h6000)), 2'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         endcase
      end

`ifdef PMP_ARB_FAULT_CNT_EN
      @(negedge clock); #1;
      check("rand_fault_count", fault_count, 16'(exp_fc));
      csr_op(1'b1, 12'h3B0, 32'h0000_1000);
      csr_op(1'b1, 12'h3A0, 32'h0000_0009);
      do_reset();
      for (int i = 0; i < 3; i++) issue(1'b0, 32'h0000_0100, 2'b01, 2'b00, WRITE);
      @(negedge clock); #1;
      check("fault_count_3", fault_count, 16'd3);
      do_reset();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
